// File: rtl/sdr_16_rd_capture_pkg.sv
// Shared SDR-16 constants: SDRAM command encodings, legal CAS latencies,
// port-id width, and the read tag carried through the CAS-latency delay line.
package sdr_16_rd_capture_pkg;

    // {ras_n, cas_n, we_n} as driven on the pads
    localparam logic [2:0] CMD_LMR   = 3'b000;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_BST   = 3'b110;
    localparam logic [2:0] CMD_NOP   = 3'b111;

    localparam int CL_MIN    = 2;
    localparam int CL_MAX    = 3;
    localparam int PORT_W    = 3;
    localparam int NUM_PORTS = 1 << PORT_W;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] sel;
        logic              last;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE
    } cap_state_e;

    function automatic logic is_read(input logic cs_n, input logic [2:0] cmd);
        return !cs_n && (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/sdr_16_rd_capture_rd_tag_delay.sv
// Fixed-depth shift register that delays a read tag by the CAS latency,
// so the tag leaves the last stage in the cycle its hi halfword is on dq.
module rd_tag_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic         sdram_clk,
    input  logic         wb_rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] stage_reg;
            logic [W-1:0] stage_next;

            if (gi == 0) begin : g_head
                assign stage_next = d;
            end else begin : g_tail
                assign stage_next = g_stage[gi-1].stage_reg;
            end

            always_ff @(posedge sdram_clk) begin
                if (wb_rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_next;
                end
            end
        end
    endgenerate

    assign q = g_stage[DEPTH-1].stage_reg;

endmodule

// File: rtl/sdr_16_rd_capture.sv
// Read-return capture: delays each READ tag by CL, packs the two BL=2 halfwords
// into one 32-bit word and writes it to the tagged port's rx FIFO (or drops it).
module sdr_16_rd_capture
    import sdr_16_rd_capture_pkg::*;
#(
    parameter int CL     = 2,
    parameter int DROP_W = 8
) (
    input  logic                 sdram_clk,
    input  logic                 wb_rst,
    input  logic                 cs_n_pad_i,
    input  logic [2:0]           cmd_pad_i,
    input  logic [PORT_W-1:0]    rd_sel_i,
    input  logic                 rd_last_i,
    input  logic [15:0]          dq_i,
    input  logic [NUM_PORTS-1:0] rx_fifo_full_i,
    output logic [31:0]          rx_dat_o,
    output logic [PORT_W-1:0]    rx_sel_o,
    output logic                 rx_last_o,
    output logic                 rx_we_o,
    output logic                 overrun_o,
    output logic                 prot_err_o,
    output logic [DROP_W-1:0]    drop_cnt_o
);

    rd_tag_t           tag_in;
    rd_tag_t           tag_out;
    logic [TAG_W-1:0]  tag_out_bits;

    cap_state_e        state_reg;
    cap_state_e        state_next;
    cap_state_e        cur_state;
    logic              hi_en;
    logic              lo_en;
    logic              write_cyc;
    logic              fifo_full;
    logic              drop;
    logic              collide;

    logic [15:0]       hi_reg;
    logic [PORT_W-1:0] cap_sel_reg;
    logic              cap_last_reg;
    logic [31:0]       rx_dat_reg;
    logic [PORT_W-1:0] rx_sel_reg;
    logic              rx_last_reg;
    logic              overrun_reg;
    logic              prot_err_reg;
    logic [DROP_W-1:0] drop_cnt_reg;

    assign tag_in = '{valid: is_read(cs_n_pad_i, cmd_pad_i), sel: rd_sel_i, last: rd_last_i};

    rd_tag_delay #(
        .DEPTH (CL),
        .W     (TAG_W)
    ) u_tag_delay (
        .sdram_clk (sdram_clk),
        .wb_rst    (wb_rst),
        .d         (tag_in),
        .q         (tag_out_bits)
    );

    assign tag_out = rd_tag_t'(tag_out_bits);

    always_ff @(posedge sdram_clk) begin
        if (wb_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // HI is never a registered state: the hi halfword is taken in the cycle the
    // tag leaves the delay line, which may overlap the previous word's WRITE
    // (gapless streaming) or its LO (burst interrupt, which abandons that word).
    always_comb begin
        cur_state  = state_reg;
        state_next = ST_IDLE;
        hi_en      = 1'b0;
        lo_en      = 1'b0;
        if (tag_out.valid) begin
            cur_state = ST_HI;
        end
        case (cur_state)
            ST_HI: begin
                hi_en      = 1'b1;
                state_next = ST_LO;
            end
            ST_LO: begin
                lo_en      = 1'b1;
                state_next = ST_WRITE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign write_cyc = (state_reg == ST_WRITE);
    assign fifo_full = rx_fifo_full_i[rx_sel_reg];
    assign drop      = write_cyc && fifo_full;
    assign collide   = tag_out.valid && (state_reg == ST_LO);

    always_ff @(posedge sdram_clk) begin
        if (wb_rst) begin
            hi_reg       <= '0;
            cap_sel_reg  <= '0;
            cap_last_reg <= 1'b0;
            rx_dat_reg   <= '0;
            rx_sel_reg   <= '0;
            rx_last_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
            prot_err_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (hi_en) begin
                hi_reg       <= dq_i;
                cap_sel_reg  <= tag_out.sel;
                cap_last_reg <= tag_out.last;
            end
            if (lo_en) begin
                rx_dat_reg  <= {hi_reg, dq_i};
                rx_sel_reg  <= cap_sel_reg;
                rx_last_reg <= cap_last_reg;
            end
            if (collide) begin
                prot_err_reg <= 1'b1;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
                if (drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
                end
            end
        end
    end

    assign rx_we_o    = write_cyc && !fifo_full;
    assign rx_dat_o   = rx_dat_reg;
    assign rx_sel_o   = rx_sel_reg;
    assign rx_last_o  = rx_last_reg;
    assign overrun_o  = overrun_reg;
    assign prot_err_o = prot_err_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Scoreboard bench for sdr_16_rd_capture: a CL=2 and a CL=3 instance, each with
// its own stimulus; expected writes are queued at issue and popped by monitors.
module tb_sdr_16_rd_capture;
    import sdr_16_rd_capture_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        logic [2:0]  sel;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        cs_n     [2];
    logic [2:0]  cmd      [2];
    logic [2:0]  sel      [2];
    logic        last     [2];
    logic [15:0] dq       [2];
    logic [7:0]  full     [2];
    logic [31:0] rx_dat   [2];
    logic [2:0]  rx_sel   [2];
    logic        rx_last  [2];
    logic        rx_we    [2];
    logic        overrun  [2];
    logic        prot_err [2];
    logic [7:0]  drop_cnt [2];

    logic [15:0] dq_sched [2][0:4095];
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sdr_16_rd_capture #(.CL(2), .DROP_W(8)) dut_cl2 (
        .sdram_clk (clk), .wb_rst (rst[0]), .cs_n_pad_i (cs_n[0]), .cmd_pad_i (cmd[0]),
        .rd_sel_i (sel[0]), .rd_last_i (last[0]), .dq_i (dq[0]), .rx_fifo_full_i (full[0]),
        .rx_dat_o (rx_dat[0]), .rx_sel_o (rx_sel[0]), .rx_last_o (rx_last[0]), .rx_we_o (rx_we[0]),
        .overrun_o (overrun[0]), .prot_err_o (prot_err[0]), .drop_cnt_o (drop_cnt[0])
    );

    sdr_16_rd_capture #(.CL(3), .DROP_W(8)) dut_cl3 (
        .sdram_clk (clk), .wb_rst (rst[1]), .cs_n_pad_i (cs_n[1]), .cmd_pad_i (cmd[1]),
        .rd_sel_i (sel[1]), .rd_last_i (last[1]), .dq_i (dq[1]), .rx_fifo_full_i (full[1]),
        .rx_dat_o (rx_dat[1]), .rx_sel_o (rx_sel[1]), .rx_last_o (rx_last[1]), .rx_we_o (rx_we[1]),
        .overrun_o (overrun[1]), .prot_err_o (prot_err[1]), .drop_cnt_o (drop_cnt[1])
    );

    // cycle counter and dq replay from the per-cycle schedule
    always @(posedge clk) begin
        cyc++;
        #1;
        dq[0] = dq_sched[0][cyc];
        dq[1] = dq_sched[1][cyc];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int idx);
        exp_t e;
        int   n;
        n = (idx == 0) ? exp_q0.size() : exp_q1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we[%0d]: strobe at cycle %0d, none expected", idx, cyc);
        end else begin
            if (idx == 0) e = exp_q0.pop_front();
            else          e = exp_q1.pop_front();
            chk($sformatf("we_cycle[%0d]", idx), cyc, e.cyc);
            chk($sformatf("rx_dat[%0d]", idx), rx_dat[idx], e.dat);
            chk($sformatf("rx_sel[%0d]", idx), {29'd0, rx_sel[idx]}, {29'd0, e.sel});
            chk($sformatf("rx_last[%0d]", idx), {31'd0, rx_last[idx]}, {31'd0, e.last});
            $display("write[%0d] cycle %0d dat=%h sel=%0d last=%0d", idx, cyc, rx_dat[idx],
                     rx_sel[idx], rx_last[idx]);
        end
    endtask

    always @(negedge clk) begin
        if (rx_we[0] === 1'b1) mon(0);
        if (rx_we[1] === 1'b1) mon(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cs_n[i] = 1'b1;
            cmd[i]  = CMD_NOP;
            sel[i]  = 3'd0;
            last[i] = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // READ on the pads in the current cycle; hi/lo returned CL and CL+1 cycles later
    task automatic rd(input int idx, input logic [2:0] s, input logic l,
                      input logic [15:0] hi, input logic [15:0] lo, input bit expect_wr);
        int   cl;
        exp_t e;
        cl = idx + 2;
        cs_n[idx] = 1'b0;
        cmd[idx]  = CMD_READ;
        sel[idx]  = s;
        last[idx] = l;
        dq_sched[idx][cyc+cl]   = hi;
        dq_sched[idx][cyc+cl+1] = lo;
        if (expect_wr) begin
            e.cyc  = cyc + cl + 2;
            e.dat  = {hi, lo};
            e.sel  = s;
            e.last = l;
            if (idx == 0) exp_q0.push_back(e);
            else          exp_q1.push_back(e);
        end
        $display("read[%0d] cycle %0d sel=%0d last=%0d hi=%h lo=%h expect_write=%0d",
                 idx, cyc, s, l, hi, lo, expect_wr);
    endtask

    task automatic check_reset(input int idx);
        chk($sformatf("rst_we[%0d]", idx), {31'd0, rx_we[idx]}, 32'd0);
        chk($sformatf("rst_overrun[%0d]", idx), {31'd0, overrun[idx]}, 32'd0);
        chk($sformatf("rst_prot_err[%0d]", idx), {31'd0, prot_err[idx]}, 32'd0);
        chk($sformatf("rst_drop_cnt[%0d]", idx), {24'd0, drop_cnt[idx]}, 32'd0);
        chk($sformatf("rst_dat[%0d]", idx), rx_dat[idx], 32'd0);
        chk($sformatf("rst_sel[%0d]", idx), {29'd0, rx_sel[idx]}, 32'd0);
        chk($sformatf("rst_last[%0d]", idx), {31'd0, rx_last[idx]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4096; c++) dq_sched[i][c] = 16'h0000;
            rst[i]  = 1'b1;
            cs_n[i] = 1'b1;
            cmd[i]  = CMD_NOP;
            sel[i]  = 3'd0;
            last[i] = 1'b0;
            dq[i]   = 16'h0000;
            full[i] = 8'h00;
        end
        steps(3);
        check_reset(0);
        check_reset(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();

        // single READ, CL=2
        rd(0, 3'd5, 1'b1, 16'hA5A5, 16'h5A5A, 1'b1);
        steps(8);
        chk("hold_dat", rx_dat[0], 32'hA5A55A5A);

        // four gapless READs, CL=3, last only on the fourth
        for (int k = 0; k < 4; k++) begin
            rd(1, 3'd2, (k == 3), 16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b1);
            steps(2);
        end
        // three gapless READs, CL=2, varying ports
        rd(0, 3'd0, 1'b0, 16'h0101, 16'h0202, 1'b1);
        steps(2);
        rd(0, 3'd7, 1'b0, 16'h7777, 16'h8888, 1'b1);
        steps(2);
        rd(0, 3'd4, 1'b1, 16'h4444, 16'h4545, 1'b1);
        steps(10);
        chk("hold_last_cl3", {31'd0, rx_last[1]}, 32'd1);

        // drops into a full FIFO; another port still gets written
        full[0] = 8'h08;
        rd(0, 3'd3, 1'b0, 16'hBAD0, 16'hBAD1, 1'b0);
        steps(2);
        rd(0, 3'd4, 1'b1, 16'h600D, 16'hF00D, 1'b1);
        steps(8);
        chk("overrun", {31'd0, overrun[0]}, 32'd1);
        chk("drop_cnt_1", {24'd0, drop_cnt[0]}, 32'd1);
        for (int k = 0; k < 253; k++) begin
            rd(0, 3'd3, 1'b0, 16'(k), 16'hFFFF, 1'b0);
            steps(2);
        end
        steps(6);
        chk("drop_cnt_254", {24'd0, drop_cnt[0]}, 32'hFE);
        rd(0, 3'd3, 1'b0, 16'h1111, 16'h2222, 1'b0);
        steps(8);
        chk("drop_cnt_255", {24'd0, drop_cnt[0]}, 32'hFF);
        for (int k = 0; k < 45; k++) begin
            rd(0, 3'd3, 1'b1, 16'h3333, 16'(k), 1'b0);
            steps(2);
        end
        steps(6);
        chk("drop_cnt_sat", {24'd0, drop_cnt[0]}, 32'hFF);
        full[0] = 8'h00;

        // burst interrupt on CL=3: second READ overwrites the dq slots
        rd(1, 3'd1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b0);
        step();
        rd(1, 3'd6, 1'b1, 16'h1234, 16'h5678, 1'b1);
        steps(10);
        chk("prot_err_cl3", {31'd0, prot_err[1]}, 32'd1);
        chk("prot_drop_cnt", {24'd0, drop_cnt[1]}, 32'd0);
        chk("prot_overrun", {31'd0, overrun[1]}, 32'd0);
        chk("no_prot_err_cl2", {31'd0, prot_err[0]}, 32'd0);

        // reset at T+CL after a READ at T
        rd(0, 3'd2, 1'b1, 16'hCCCC, 16'hDDDD, 1'b0);
        steps(2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        steps(8);
        check_reset(0);

        // non-READ commands and READ with cs_n high are ignored
        cs_n[0] = 1'b0;
        cmd[0]  = CMD_WRITE;
        sel[0]  = 3'd1;
        dq_sched[0][cyc+2] = 16'hEEEE;
        dq_sched[0][cyc+3] = 16'hEEEE;
        step();
        cs_n[0] = 1'b1;
        cmd[0]  = CMD_READ;
        sel[0]  = 3'd2;
        step();
        cs_n[0] = 1'b0;
        cmd[0]  = CMD_ACT;
        step();
        cs_n[0] = 1'b0;
        cmd[0]  = CMD_BST;
        steps(8);
        chk("ignored_dat", rx_dat[0], 32'd0);
        rd(0, 3'd6, 1'b0, 16'hCAFE, 16'hF00D, 1'b1);
        steps(8);
        chk("final_dat", rx_dat[0], 32'hCAFEF00D);

        chk("leftover_q0", exp_q0.size(), 32'd0);
        chk("leftover_q1", exp_q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdr_16_rd_capture.md
# sdr_16_rd_capture

Read-return capture stage for the 16-bit SDR SDRAM path. It watches the command pins driven to the SDRAM and, after the CAS latency, samples the two 16-bit halves of each read burst from `dq_i`. It packs them into one 32-bit word, tagged with the requesting port, and writes that word into the per-port rx FIFO. It sits directly downstream of the `sdr_16` pad registers and is the mirror of the tx write-data path: one READ of BL=2 returns one Wishbone word.

## Interface
Parameters:
- `CL`, 2, CAS latency in sdram_clk cycles; legal values 2 and 3.
- `DROP_W`, 8, width of the saturating dropped-word counter.

Ports:
- `sdram_clk` in 1: the only clock.
- `wb_rst` in 1: synchronous, active-high reset.
- `cs_n_pad_i` in 1: chip select as driven on the pads this cycle.
- `cmd_pad_i` in 3: {ras, cas, we} as driven on the pads this cycle.
- `rd_sel_i` in 3: port id of the read; valid in the cycle the READ is on the pads.
- `rd_last_i` in 1: final word of the Wishbone burst; same timing as `rd_sel_i`.
- `dq_i` in 16: SDRAM data bus.
- `rx_fifo_full_i` in 8: per-port rx FIFO full flags.
- `rx_dat_o` out 32: packed word; the first halfword goes to [31:16].
- `rx_sel_o` out 3: destination FIFO / port.
- `rx_last_o` out 1: copy of the tagged `rd_last_i`.
- `rx_we_o` out 1: one-cycle write strobe to the rx FIFO.
- `overrun_o` out 1: sticky flag; a word was dropped because its FIFO was full.
- `prot_err_o` out 1: sticky flag; READ commands were spaced less than 2 cycles apart.
- `drop_cnt_o` out DROP_W: count of dropped words, saturating.

## Operation
- READ decode: `!cs_n_pad_i & cmd_pad_i == CMD_READ`. All other commands, and any cycle with cs_n high, are ignored.
- On a READ, push the tag {valid, sel, last} into a tag delay line of depth CL.
- Capture state machine:
  - IDLE: wait for the tag to emerge from the delay line.
  - HI: latch `dq_i` into hi[15:0].
  - LO: latch `dq_i` into lo[15:0].
  - Then WRITE, or HI again if another tag emerges this cycle.
- WRITE: drive `rx_dat_o` = {hi, lo} together with the tag's sel and last.
  - If `rx_fifo_full_i[sel]` is clear: assert `rx_we_o`.
  - If it is set: hold `rx_we_o` low, set `overrun_o`, increment `drop_cnt_o` (saturating at all-ones).
- There is no back-pressure toward the SDRAM. Data is never stalled; it is either written or dropped.
- Back-to-back READs 2 cycles apart stream gaplessly:
  - The HI of the next word coincides with the WRITE cycle of the previous word.
  - The pipeline must hold two words in flight.
- READ 1 cycle after a READ emulates SDRAM burst interrupt:
  - The first word's LO is never captured; that word is discarded with no write.
  - The second READ is captured normally.
  - `prot_err_o` is set.
  - `drop_cnt_o` is not incremented.
- Reset values:
  - `rx_we_o`, `overrun_o`, `prot_err_o` = 0.
  - `drop_cnt_o` = 0; `rx_dat_o` = 0; `rx_sel_o` = 0; `rx_last_o` = 0.
  - Delay line cleared; state machine in IDLE.
- Reset mid-burst: every in-flight tag is discarded, and no `rx_we_o` occurs for READs issued before reset.
- Sticky flags clear only on `wb_rst`.

## Timing
- READ on pads at cycle T:
  - hi sampled at the edge ending cycle T+CL.
  - lo sampled at the edge ending cycle T+CL+1.
  - `rx_we_o` high during cycle T+CL+2, for exactly one cycle.
- Latency from READ on pads to `rx_we_o` is CL+2 cycles.
- `rx_dat_o`, `rx_sel_o` and `rx_last_o` are registered. They are valid in the `rx_we_o` cycle and hold their value until the next WRITE.
- The full check uses `rx_fifo_full_i` as sampled combinationally in the WRITE cycle.
- Maximum sustained rate: one word every 2 cycles.

## Structure
- The shared defines file holds:
  - the CMD_* encodings (CMD_NOP, CMD_READ, CMD_WRITE, ...);
  - the legal CL values;
  - the 3-bit port-id width.
- These are the same constants `sdr_16` uses.
- Sub-module `rd_tag_delay`: a parameterized shift register (depth CL, width 5), with synchronous clear on `wb_rst`.
- The capture state machine, packing registers and error/counter logic stay in `sdr_16_rd_capture`.

## Test plan
- CL=2, single READ at T with sel=5, last=1; dq=16'hA5A5 then 16'h5A5A -> at T+4: `rx_we_o`=1, `rx_dat_o`=32'hA5A55A5A, `rx_sel_o`=5, `rx_last_o`=1.
- CL=3, four READs at T, T+2, T+4, T+6, sel=2, last only on the fourth -> `rx_we_o` pulses at T+5, T+7, T+9, T+11 with the correct words; `rx_last_o`=1 only on the fourth.
- READ with `rx_fifo_full_i[3]`=1 at its WRITE cycle, sel=3 -> no `rx_we_o`; `overrun_o`=1; `drop_cnt_o`=1. After 300 such drops, `drop_cnt_o`=8'hFF.
- READs at T and T+1 -> exactly one `rx_we_o` at T+CL+3, carrying the second READ's data and tag; `prot_err_o`=1; `drop_cnt_o` unchanged.
- `wb_rst` asserted for one cycle at T+CL after a READ at T -> no `rx_we_o` afterwards; all outputs at reset values.
- WRITE command, and READ encoding with cs_n=1 -> no capture, no strobe.
